wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Writeback trace capture buffer sitting directly downstream of the processor/regfile top level. It samples each register-file write (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`) together with the fetch address `address_imem`, once per processor cycle. Samples go into a FIFO, and a host or logic analyser drains the FIFO over a valid/ready port. The buffer runs on the undivided master clock and uses a per-processor-cycle strobe, so it sees every write exactly once even though the processor runs on a divided clock.

## Interface
- `DEPTH`, 16, number of FIFO entries; must be a power of two, ≥ 2.
- `STOP_ON_FULL`, 0, when 1, the buffer enters HALT when a push makes the FIFO full.
- `clock` in 1, master clock (undivided).
- `reset` in 1, synchronous, active-low; sampled on the rising edge of `clock`.
- `proc_tick` in 1, one-cycle strobe per processor cycle; samples are valid only when it is high.
- `wb_we` in 1, regfile write enable.
- `wb_reg` in 5, destination register.
- `wb_data` in 32, write data.
- `wb_pc` in 12, imem address of the writing instruction.
- `arm` in 1, pulse: start capture (RUN).
- `halt_req` in 1, pulse: stop capture (HALT).
- `out_ready` in 1, consumer accepts the head entry.
- `out_valid` out 1, head entry present.
- `out_pc` out 12, head entry: imem address.
- `out_reg` out 5, head entry: destination register.
- `out_data` out 32, head entry: write data.
- `out_stamp` out 16, head entry timestamp (see Configuration).
- `level` out $clog2(DEPTH)+1, current occupancy.
- `overflow` out 1, sticky; a sample was dropped.
- `drop_count` out 16, number of dropped samples, saturating.
- `state` out 2, 0 = IDLE, 1 = RUN, 2 = HALT.

## Operation
- FSM transitions:
  - IDLE: `arm` → RUN.
  - RUN: `halt_req` → HALT. With `STOP_ON_FULL` = 1, a push that makes `level` = DEPTH → HALT.
  - HALT: `arm` → RUN, clears `overflow` and `drop_count`; FIFO contents are kept.
  - If `arm` and `halt_req` are high in the same cycle, `halt_req` wins.
- Capture condition: state = RUN && `proc_tick` && `wb_we` && `wb_reg` ≠ 0. Writes to $0 are never traced.
- Push is accepted when `level` < DEPTH, or when a pop occurs in the same cycle.
- When full with no pop, the sample is dropped: `overflow` ← 1, `drop_count` += 1, saturating at 0xFFFF.
- Pop occurs when `out_valid && out_ready`. Draining is allowed in every state, including IDLE.
- Simultaneous push and pop: `level` is unchanged, and the order is preserved.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `level` is a separate counter.
- Reset mid-operation discards FIFO contents. All outputs reset to 0: `out_valid` = 0, `level` = 0, `overflow` = 0, `drop_count` = 0, `state` = IDLE, and data outputs = 0.

## Timing
- Capture to visibility: an entry pushed at edge N is at the head, with `out_valid` = 1, after edge N, so it is readable in cycle N+1. There is no combinational fall-through from `wb_*` to `out_*`.
- `out_*` are registered and stable while `out_valid && !out_ready`.
- The next head appears in the cycle after a pop. Back-to-back pops sustain one entry per clock.
- `level`, `overflow`, `drop_count` and `state` update on the same edge as the push, pop or drop that changes them.
- A `halt_req` in the same cycle as a qualifying sample: the sample is not captured, because HALT takes priority.

## Configuration
- `WB_TRACE_TIMESTAMP_EN` defined:
  - A 16-bit free-running counter counts `proc_tick` pulses from reset and wraps at 0xFFFF→0.
  - Each entry stores the counter value at capture. `out_stamp` presents the head entry's stamp.
- Not defined:
  - No counter and no stamp storage.
  - `out_stamp` is tied to 0. The port is always present.

## Structure
- Shared package `wb_trace_pkg`:
  - state encoding constants: `WBT_IDLE`, `WBT_RUN`, `WBT_HALT`;
  - entry field widths: PC 12, REG 5, DATA 32, STAMP 16;
  - `DROP_MAX` = 16'hFFFF.
- Sub-module `wb_trace_fifo`: a synchronous FIFO, parameterised by width and depth, with push/pop/level. The top level holds the FSM, the capture qualifier, the drop logic and the timestamp.

## Test plan
- Reset, `arm`, then three ticks writing r5=0x11, r0=0x22, r7=0x33 → exactly two entries (r5 then r7), `level` = 2; $0 is not traced.
- DEPTH=16, `out_ready` = 0, 20 qualifying ticks → `level` = 16, `overflow` = 1, `drop_count` = 4; the head is the first sample.
- Full FIFO with `out_ready` = 1 and a qualifying tick in the same cycle → `level` stays 16, no drop, FIFO order correct after draining.
- `STOP_ON_FULL` = 1: 16 ticks → `state` = HALT on the 16th push; a 17th tick is ignored with `drop_count` = 0. Then `arm` → RUN.
- `reset` held low for one edge with 5 entries queued → `level` = 0, `out_valid` = 0, `state` = IDLE on the next cycle.
- With `WB_TRACE_TIMESTAMP_EN`: samples on tick numbers 3 and 9 → `out_stamp` = 3, then 9. Without the macro → `out_stamp` = 0.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// Shared definitions for the writeback trace buffer: state encoding,
// entry field widths and the drop counter saturation value.
package wb_trace_pkg;

    localparam int PC_W    = 12;
    localparam int REG_W   = 5;
    localparam int DATA_W  = 32;
    localparam int STAMP_W = 16;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        WBT_IDLE = 2'd0,
        WBT_RUN  = 2'd1,
        WBT_HALT = 2'd2
    } wbt_state_e;

    // Captured writeback fields; the optional stamp is appended outside
    // this struct so the default build carries no stamp storage.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wbt_core_t;

    localparam int CORE_W = $bits(wbt_core_t);

endpackage

// File: rtl/wb_trace_fifo.sv
// Synchronous FIFO with separate occupancy counter. Head data is read from
// the storage registers and forced to zero while empty, so nothing from the
// push side reaches dout in the same cycle.
module wb_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (level != '0);
    assign full    = (level == FULL_LVL);
    assign do_pop  = pop && valid;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign dout    = valid ? mem[rd_ptr] : '0;

    // Storage write; contents need no reset since level gates visibility.
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace capture buffer. Qualifies regfile writes once per
// processor cycle, queues them in wb_trace_fifo and exposes the head on a
// valid/ready port. Holds the capture FSM, drop accounting and timestamp.
// Optional feature macro: WB_TRACE_TIMESTAMP_EN (per-entry tick stamp).
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter bit STOP_ON_FULL = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     proc_tick,
    input  logic                     wb_we,
    input  logic [4:0]               wb_reg,
    input  logic [31:0]              wb_data,
    input  logic [11:0]              wb_pc,
    input  logic                     arm,
    input  logic                     halt_req,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [11:0]              out_pc,
    output logic [4:0]               out_reg,
    output logic [31:0]              out_data,
    output logic [15:0]              out_stamp,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic [1:0]               state
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LAST_FREE = LW'(DEPTH - 1);

`ifdef WB_TRACE_TIMESTAMP_EN
    localparam int FW = CORE_W + STAMP_W;
`else
    localparam int FW = CORE_W;
`endif

    wbt_state_e       st;
    wbt_core_t        cap_ent;
    logic [FW-1:0]    fifo_din;
    logic [FW-1:0]    fifo_dout;
    logic             fifo_valid;
    logic             fifo_full;
    logic [LW-1:0]    fifo_level;
    logic             capture;
    logic             pop;
    logic             push;
    logic             drop;
    logic             fills;

    assign cap_ent = '{pc: wb_pc, rd: wb_reg, data: wb_data};

    // A halt request in the same cycle suppresses the sample.
    assign capture = (st == WBT_RUN) && proc_tick && wb_we && (wb_reg != 5'd0) && !halt_req;
    assign pop     = fifo_valid && out_ready;
    assign push    = capture && (!fifo_full || pop);
    assign drop    = capture && !push;
    // This push takes the last free slot (no pop to offset it).
    assign fills   = push && !pop && (fifo_level == LAST_FREE);

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [STAMP_W-1:0] tick_cnt;

    // Free-running count of processor ticks since reset; wraps at 0xFFFF.
    always_ff @(posedge clock) begin
        if (!reset)
            tick_cnt <= '0;
        else if (proc_tick)
            tick_cnt <= tick_cnt + 1'b1;
    end

    assign fifo_din = {cap_ent, tick_cnt};
    assign {out_pc, out_reg, out_data, out_stamp} = fifo_dout;
`else
    assign fifo_din = cap_ent;
    assign {out_pc, out_reg, out_data} = fifo_dout;
    assign out_stamp = '0;
`endif

    wb_trace_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .full  (fifo_full),
        .level (fifo_level)
    );

    // Capture FSM plus sticky overflow and saturating drop counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            st         <= WBT_IDLE;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            case (st)
                WBT_IDLE: begin
                    if (arm && !halt_req)
                        st <= WBT_RUN;
                end
                WBT_RUN: begin
                    if (halt_req)
                        st <= WBT_HALT;
                    else if (STOP_ON_FULL && fills)
                        st <= WBT_HALT;
                end
                WBT_HALT: begin
                    if (arm && !halt_req) begin
                        st         <= WBT_RUN;
                        overflow   <= 1'b0;
                        drop_count <= '0;
                    end
                end
                default: st <= WBT_IDLE;
            endcase
            // Drops only occur in RUN, so they never collide with the clear.
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != DROP_MAX)
                    drop_count <= drop_count + 1'b1;
            end
        end
    end

    assign out_valid = fifo_valid;
    assign level     = fifo_level;
    assign state     = st;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: capture filter, overflow/drop,
// push+pop at full, halt priority, re-arm clear, reset, stop-on-full
// and per-entry timestamps (WB_TRACE_TIMESTAMP_EN).
module tb_wb_trace_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        proc_tick, wb_we, arm, halt_req, out_ready;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [11:0] wb_pc;

    logic        a_valid, b_valid;
    logic [11:0] a_pc, b_pc;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic [15:0] a_stamp, b_stamp;
    logic [4:0]  a_level, b_level;
    logic        a_ovf, b_ovf;
    logic [15:0] a_drop, b_drop;
    logic [1:0]  a_state, b_state;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    wb_trace_buffer #(.DEPTH(16), .STOP_ON_FULL(1'b0)) u_dut (
        .clock(clock), .reset(reset), .proc_tick(proc_tick), .wb_we(wb_we),
        .wb_reg(wb_reg), .wb_data(wb_data), .wb_pc(wb_pc), .arm(arm),
        .halt_req(halt_req), .out_ready(out_ready), .out_valid(a_valid),
        .out_pc(a_pc), .out_reg(a_reg), .out_data(a_data), .out_stamp(a_stamp),
        .level(a_level), .overflow(a_ovf), .drop_count(a_drop), .state(a_state)
    );

    wb_trace_buffer #(.DEPTH(16), .STOP_ON_FULL(1'b1)) u_stop (
        .clock(clock), .reset(reset), .proc_tick(proc_tick), .wb_we(wb_we),
        .wb_reg(wb_reg), .wb_data(wb_data), .wb_pc(wb_pc), .arm(arm),
        .halt_req(halt_req), .out_ready(out_ready), .out_valid(b_valid),
        .out_pc(b_pc), .out_reg(b_reg), .out_data(b_data), .out_stamp(b_stamp),
        .level(b_level), .overflow(b_ovf), .drop_count(b_drop), .state(b_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic t, input logic we, input logic [4:0] r,
                         input logic [31:0] d, input logic [11:0] p);
        proc_tick = t; wb_we = we; wb_reg = r; wb_data = d; wb_pc = p;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [15:0] exp_s3, exp_s9;
`ifdef WB_TRACE_TIMESTAMP_EN
        exp_s3 = 16'd3; exp_s9 = 16'd9;
`else
        exp_s3 = 16'd0; exp_s9 = 16'd0;
`endif
        reset = 1'b0; arm = 1'b0; halt_req = 1'b0; out_ready = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 12'd0);
        step(); step();
        reset = 1'b1;

        // Reset state
        chk("rst_state", 32'(a_state), 32'd0);
        chk("rst_level", 32'(a_level), 32'd0);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_ovf",   32'(a_ovf),   32'd0);
        chk("rst_drop",  32'(a_drop),  32'd0);
        chk("rst_data",  a_data,       32'd0);
        chk("rst_stamp", 32'(a_stamp), 32'd0);

        // Samples before arm are not captured
        drive(1'b1, 1'b1, 5'd3, 32'hAA, 12'h0);
        step();
        chk("idle_nocap", 32'(a_level), 32'd0);

        arm = 1'b1; drive(1'b0, 1'b0, 5'd0, 32'd0, 12'd0);
        step();
        arm = 1'b0;
        chk("arm_run", 32'(a_state), 32'd1);

        // r5, r0, r7: $0 filtered out
        drive(1'b1, 1'b1, 5'd5, 32'h11, 12'h100); step();
        chk("first_vis", 32'(a_valid), 32'd1);
        drive(1'b1, 1'b1, 5'd0, 32'h22, 12'h101); step();
        drive(1'b1, 1'b1, 5'd7, 32'h33, 12'h102); step();
        // no proc_tick, and proc_tick without we: both ignored
        drive(1'b0, 1'b1, 5'd9, 32'h44, 12'h103); step();
        drive(1'b1, 1'b0, 5'd9, 32'h55, 12'h104); step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 12'd0);
        chk("filt_level", 32'(a_level), 32'd2);
        chk("filt_reg0",  32'(a_reg),   32'd5);
        chk("filt_data0", a_data,       32'h11);
        chk("filt_pc0",   32'(a_pc),    32'h100);
        out_ready = 1'b1; step();
        chk("filt_reg1",  32'(a_reg),   32'd7);
        chk("filt_data1", a_data,       32'h33);
        chk("filt_pc1",   32'(a_pc),    32'h102);
        chk("filt_lvl1",  32'(a_level), 32'd1);
        step();
        out_ready = 1'b0;
        chk("drain_lvl", 32'(a_level), 32'd0);
        chk("drain_vld", 32'(a_valid), 32'd0);

        // 20 samples into DEPTH 16 with no consumer
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 5'd3, 32'h100 + 32'(i), 12'(i));
            step();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 12'd0);
        chk("ovf_level", 32'(a_level), 32'd16);
        chk("ovf_flag",  32'(a_ovf),   32'd1);
        chk("ovf_drop",  32'(a_drop),  32'd4);
        chk("ovf_head",  a_data,       32'h100);

        // Holding with out_ready low keeps the head stable
        step();
        chk("ovf_hold", a_data, 32'h100);

        // Full + pop + push in one cycle: no drop, level held
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 5'd4, 32'h200, 12'h200);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 12'd0);
        chk("pp_level", 32'(a_level), 32'd16);
        chk("pp_drop",  32'(a_drop),  32'd4);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pp_order%0d", i), a_data, (i < 15) ? (32'h101 + 32'(i)) : 32'h200);
            step();
        end
        out_ready = 1'b0;
        chk("pp_empty", 32'(a_level), 32'd0);

        // Halt in same cycle as a qualifying sample: not captured
        halt_req = 1'b1; drive(1'b1, 1'b1, 5'd4, 32'h55, 12'h0);
        step();
        halt_req = 1'b0; drive(1'b0, 1'b0, 5'd0, 32'd0, 12'd0);
        chk("halt_state", 32'(a_state), 32'd2);
        chk("halt_nocap", 32'(a_level), 32'd0);
        // Halted: samples ignored
        drive(1'b1, 1'b1, 5'd4, 32'h56, 12'h0); step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 12'd0);
        chk("halt_ign", 32'(a_level), 32'd0);
        arm = 1'b1; step(); arm = 1'b0;
        chk("rearm_state", 32'(a_state), 32'd1);
        chk("rearm_ovf",   32'(a_ovf),   32'd0);
        chk("rearm_drop",  32'(a_drop),  32'd0);
        arm = 1'b1; halt_req = 1'b1; step(); arm = 1'b0; halt_req = 1'b0;
        chk("arm_halt_pri", 32'(a_state), 32'd2);
        arm = 1'b1; step(); arm = 1'b0;
        chk("rearm2", 32'(a_state), 32'd1);

        // Reset with 5 entries queued
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 5'd8, 32'h300 + 32'(i), 12'(i));
            step();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 12'd0);
        chk("pre_rst_lvl", 32'(a_level), 32'd5);
        reset = 1'b0; step(); reset = 1'b1;
        chk("mid_rst_lvl",   32'(a_level), 32'd0);
        chk("mid_rst_vld",   32'(a_valid), 32'd0);
        chk("mid_rst_state", 32'(a_state), 32'd0);
        chk("mid_rst_data",  a_data,       32'd0);

        // STOP_ON_FULL instance
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 5'd2, 32'h500 + 32'(i), 12'(i));
            step();
        end
        chk("sof_run15", 32'(b_state), 32'd1);
        chk("sof_lvl15", 32'(b_level), 32'd15);
        drive(1'b1, 1'b1, 5'd2, 32'h50F, 12'hF); step();
        chk("sof_halt16", 32'(b_state), 32'd2);
        chk("sof_lvl16",  32'(b_level), 32'd16);
        drive(1'b1, 1'b1, 5'd2, 32'h510, 12'h10); step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 12'd0);
        chk("sof_lvl17",  32'(b_level), 32'd16);
        chk("sof_drop17", 32'(b_drop),  32'd0);
        chk("sof_ovf17",  32'(b_ovf),   32'd0);
        chk("sof_head",   b_data,       32'h500);
        arm = 1'b1; step(); arm = 1'b0;
        chk("sof_rearm", 32'(b_state), 32'd1);

        // Timestamps: ticks numbered from 0 after reset, capture on 3 and 9
        reset = 1'b0; step(); reset = 1'b1;
        arm = 1'b1; step(); arm = 1'b0;
        for (int t = 0; t < 10; t++) begin
            drive(1'b1, (t == 3) || (t == 9), 5'd6, 32'h400 + 32'(t), 12'(t));
            step();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 12'd0);
        chk("ts_level", 32'(a_level), 32'd2);
        chk("ts_data3", a_data,       32'h403);
        chk("ts_stamp3", 32'(a_stamp), 32'(exp_s3));
        out_ready = 1'b1; step();
        chk("ts_data9", a_data,        32'h409);
        chk("ts_stamp9", 32'(a_stamp), 32'(exp_s9));
        step(); out_ready = 1'b0;
        chk("ts_empty", 32'(a_level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
